id_ex_stage: RTL and testbench

- ID/EX pipeline register for the 5-stage MIPS pipeline. It sits directly downstream of the opcode control decoder and the register file.
- Latches the 12-bit control bundle, operands, register specifiers and extended immediate each cycle.
- Detects load-use hazards: stalls upstream and injects a bubble.
- Honours branch/jump flushes from later stages.
- Counts injected bubbles for performance debug.

---
 rtl/mips_pkg.sv | 44 ++++
 rtl/hazard_unit.sv | 24 ++
 rtl/id_ex_stage.sv | 138 +++++++++++++
 tb/tb_id_ex_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: widths, control-bundle bit map, bubble value, opcodes.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mips_pkg;

    // Datapath, register-specifier and control-bundle widths
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 12;

    // Control bundle bit positions
    localparam int CTL_SIGN     = 0;
    localparam int CTL_JUMP_N   = 1;   // active-low jump
    localparam int CTL_ALUSRC   = 2;
    localparam int CTL_ALUOP_LO = 3;
    localparam int CTL_ALUOP_HI = 5;
    localparam int CTL_REGDST   = 6;
    localparam int CTL_MEMWRITE = 7;
    localparam int CTL_MEMREAD  = 8;
    localparam int CTL_BRANCH   = 9;
    localparam int CTL_REGWRITE = 10;
    localparam int CTL_MEMTOREG = 11;

    // Everything off; Jump_n held high so a bubble never looks like a jump
    localparam logic [CW-1:0] BUBBLE_CTRL = 12'b0000_0000_0010;

    // Primary opcodes shared with the control decoder
    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_ADDIU = 6'h09,
        OP_SLTI  = 6'h0A,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_LUI   = 6'h0F,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detector: a load in EX whose destination feeds a source of the ID instruction.
// Latency: purely combinational, 0 cycles.
// Backpressure: none itself; the caller turns hazard into a stall.
// Ports: ex_valid/ex_memread/ex_rt describe the EX instruction; id_valid/id_rs/id_rt the ID one;
//        hazard is high when ID must wait one cycle for the load result.
module hazard_unit
    import mips_pkg::*;
#(
    parameter int RW_P = RW
) (
    input  logic            ex_valid,
    input  logic            ex_memread,
    input  logic [RW_P-1:0] ex_rt,
    input  logic            id_valid,
    input  logic [RW_P-1:0] id_rs,
    input  logic [RW_P-1:0] id_rt,
    output logic            hazard
);

    // $zero is never a real dependency, so a load targeting r0 cannot cause a stall
    assign hazard = ex_valid & ex_memread & (ex_rt != '0) & id_valid
                  & ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, bubble injection, flush and bubble counter.
// Latency: 1 cycle ID -> EX; stall is combinational from current EX state and ID inputs.
// Backpressure: stall holds PC and IF/ID for one cycle on a load-use hazard while a bubble enters EX.
// Ports: clk/rst (sync, active-high); id_* from decoder/register file; flush kills the ID
//        instruction; stall to upstream; ex_* registered EX-stage values; bubble_cnt saturating count.
module id_ex_stage
#(
    parameter int DW   = 32,
    parameter int RW   = 5,
    parameter int CW   = 12,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [CW-1:0]   id_ctrl,
    input  logic [DW-1:0]   id_pc4,
    input  logic [DW-1:0]   id_rs_data,
    input  logic [DW-1:0]   id_rt_data,
    input  logic [15:0]     id_imm16,
    input  logic [RW-1:0]   id_rs,
    input  logic [RW-1:0]   id_rt,
    input  logic [RW-1:0]   id_rd,
    input  logic            flush,
    output logic            stall,
    output logic            ex_valid,
    output logic [CW-1:0]   ex_ctrl,
    output logic [DW-1:0]   ex_pc4,
    output logic [DW-1:0]   ex_rs_data,
    output logic [DW-1:0]   ex_rt_data,
    output logic [DW-1:0]   ex_imm,
    output logic [RW-1:0]   ex_rs,
    output logic [RW-1:0]   ex_rt,
    output logic [RW-1:0]   ex_rd,
    output logic [CNTW-1:0] bubble_cnt
);

    import mips_pkg::*;

    logic            ex_valid_q,   ex_valid_d;
    logic [CW-1:0]   ex_ctrl_q,    ex_ctrl_d;
    logic [DW-1:0]   ex_pc4_q,     ex_pc4_d;
    logic [DW-1:0]   ex_rs_data_q, ex_rs_data_d;
    logic [DW-1:0]   ex_rt_data_q, ex_rt_data_d;
    logic [DW-1:0]   ex_imm_q,     ex_imm_d;
    logic [RW-1:0]   ex_rs_q,      ex_rs_d;
    logic [RW-1:0]   ex_rt_q,      ex_rt_d;
    logic [RW-1:0]   ex_rd_q,      ex_rd_d;
    logic [CNTW-1:0] bubble_cnt_q, bubble_cnt_d;

    logic hazard;
    logic cnt_inc;
    logic [DW-1:0] imm_ext;

    hazard_unit #(
        .RW_P (RW)
    ) u_hazard (
        .ex_valid   (ex_valid_q),
        .ex_memread (ex_ctrl_q[CTL_MEMREAD]),
        .ex_rt      (ex_rt_q),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .hazard     (hazard)
    );

    // A flush already discards the ID instruction, so holding upstream would be pointless
    assign stall = hazard & ~flush & ~rst;

    // Sign bit of the control bundle selects sign- vs zero-extension
    assign imm_ext = id_ctrl[CTL_SIGN] ? {{(DW-16){id_imm16[15]}}, id_imm16}
                                       : {{(DW-16){1'b0}}, id_imm16};

    always_comb begin
        // Default: load a bubble and keep the counter
        ex_valid_d   = 1'b0;
        ex_ctrl_d    = CW'(BUBBLE_CTRL);
        ex_pc4_d     = '0;
        ex_rs_data_d = '0;
        ex_rt_data_d = '0;
        ex_imm_d     = '0;
        ex_rs_d      = '0;
        ex_rt_d      = '0;
        ex_rd_d      = '0;
        bubble_cnt_d = bubble_cnt_q;
        cnt_inc      = 1'b0;

        if (rst) begin
            bubble_cnt_d = '0;
        end else if (flush) begin
            // Only a killed real instruction counts as a lost slot
            cnt_inc = id_valid;
        end else if (hazard) begin
            cnt_inc = 1'b1;
        end else if (id_valid) begin
            // Control passes through untouched, even for unsupported opcodes
            ex_valid_d   = 1'b1;
            ex_ctrl_d    = id_ctrl;
            ex_pc4_d     = id_pc4;
            ex_rs_data_d = id_rs_data;
            ex_rt_data_d = id_rt_data;
            ex_imm_d     = imm_ext;
            ex_rs_d      = id_rs;
            ex_rt_d      = id_rt;
            ex_rd_d      = id_rd;
        end

        // Saturate rather than wrap so a long run never reads as a small count
        if (cnt_inc && (bubble_cnt_q != {CNTW{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        ex_valid_q   <= ex_valid_d;
        ex_ctrl_q    <= ex_ctrl_d;
        ex_pc4_q     <= ex_pc4_d;
        ex_rs_data_q <= ex_rs_data_d;
        ex_rt_data_q <= ex_rt_data_d;
        ex_imm_q     <= ex_imm_d;
        ex_rs_q      <= ex_rs_d;
        ex_rt_q      <= ex_rt_d;
        ex_rd_q      <= ex_rd_d;
        bubble_cnt_q <= bubble_cnt_d;
    end

    assign ex_valid   = ex_valid_q;
    assign ex_ctrl    = ex_ctrl_q;
    assign ex_pc4     = ex_pc4_q;
    assign ex_rs_data = ex_rs_data_q;
    assign ex_rt_data = ex_rt_data_q;
    assign ex_imm     = ex_imm_q;
    assign ex_rs      = ex_rs_q;
    assign ex_rt      = ex_rt_q;
    assign ex_rd      = ex_rd_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    localparam int DW   = 32;
    localparam int RW   = 5;
    localparam int CW   = 12;
    localparam int CNTW = 4;

    // Hand-encoded control bundles
    localparam logic [CW-1:0] C_ADDI = 12'b0100_0001_1111; // 0x41F, Sign=1
    localparam logic [CW-1:0] C_ORI  = 12'b0100_0001_1110; // 0x41E, Sign=0
    localparam logic [CW-1:0] C_LW   = 12'hD07;            // MemtoReg,RegWrite,MemRead,ALUSrc,Jump_n,Sign
    localparam logic [CW-1:0] C_ADD  = 12'h452;            // RegWrite,RegDst,ALUOp=010,Jump_n

    logic            clk;
    logic            rst;
    logic            id_valid;
    logic [CW-1:0]   id_ctrl;
    logic [DW-1:0]   id_pc4;
    logic [DW-1:0]   id_rs_data;
    logic [DW-1:0]   id_rt_data;
    logic [15:0]     id_imm16;
    logic [RW-1:0]   id_rs;
    logic [RW-1:0]   id_rt;
    logic [RW-1:0]   id_rd;
    logic            flush;
    logic            stall;
    logic            ex_valid;
    logic [CW-1:0]   ex_ctrl;
    logic [DW-1:0]   ex_pc4;
    logic [DW-1:0]   ex_rs_data;
    logic [DW-1:0]   ex_rt_data;
    logic [DW-1:0]   ex_imm;
    logic [RW-1:0]   ex_rs;
    logic [RW-1:0]   ex_rt;
    logic [RW-1:0]   ex_rd;
    logic [CNTW-1:0] bubble_cnt;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(
        .DW   (DW),
        .RW   (RW),
        .CW   (CW),
        .CNTW (CNTW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_ctrl    (id_ctrl),
        .id_pc4     (id_pc4),
        .id_rs_data (id_rs_data),
        .id_rt_data (id_rt_data),
        .id_imm16   (id_imm16),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rd      (id_rd),
        .flush      (flush),
        .stall      (stall),
        .ex_valid   (ex_valid),
        .ex_ctrl    (ex_ctrl),
        .ex_pc4     (ex_pc4),
        .ex_rs_data (ex_rs_data),
        .ex_rt_data (ex_rt_data),
        .ex_imm     (ex_imm),
        .ex_rs      (ex_rs),
        .ex_rt      (ex_rt),
        .ex_rd      (ex_rd),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [15:0] imm,
                         input logic [RW-1:0] rs, input logic [RW-1:0] rt, input logic [RW-1:0] rd);
        id_valid   = v;
        id_ctrl    = c;
        id_imm16   = imm;
        id_rs      = rs;
        id_rt      = rt;
        id_rd      = rd;
        id_pc4     = 32'h0000_1000 + {24'd0, 3'd0, rs} * 4;
        id_rs_data = 32'hA000_0000 | {27'd0, rs};
        id_rt_data = 32'hB000_0000 | {27'd0, rt};
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
        chk({tag, "_ctrl"},  {20'd0, ex_ctrl}, 32'h002);
        chk({tag, "_imm"},   ex_imm, 32'd0);
        chk({tag, "_rt"},    {27'd0, ex_rt}, 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        drive(1'b1, C_LW, 16'h0004, 5'd1, 5'd5, 5'd0);

        // Reset held two cycles
        tick();
        chk("rst_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("rst_stall2", {31'd0, stall}, 32'd0);
        rst = 1'b0;
        drive(1'b0, 12'h000, 16'h0000, 5'd0, 5'd0, 5'd0);
        #1;
        chk_bubble("reset");
        chk("reset_cnt", {28'd0, bubble_cnt}, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);

        // addi: sign-extended immediate
        drive(1'b1, C_ADDI, 16'hFFFC, 5'd1, 5'd2, 5'd0);
        #1;
        chk("addi_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("addi_valid", {31'd0, ex_valid}, 32'd1);
        chk("addi_ctrl", {20'd0, ex_ctrl}, 32'h41F);
        chk("addi_imm", ex_imm, 32'hFFFF_FFFC);
        chk("addi_rsd", ex_rs_data, 32'hA000_0001);
        chk("addi_rtd", ex_rt_data, 32'hB000_0002);
        chk("addi_pc4", ex_pc4, 32'h0000_1004);
        chk("addi_rs", {27'd0, ex_rs}, 32'd1);

        // ori: zero-extended immediate
        drive(1'b1, C_ORI, 16'h8001, 5'd3, 5'd4, 5'd0);
        tick();
        chk("ori_ctrl", {20'd0, ex_ctrl}, 32'h41E);
        chk("ori_imm", ex_imm, 32'h0000_8001);
        chk("ori_rt", {27'd0, ex_rt}, 32'd4);

        // Load-use: lw r5 then add using r5
        drive(1'b1, C_LW, 16'h0010, 5'd1, 5'd5, 5'd0);
        tick();
        chk("lw_valid", {31'd0, ex_valid}, 32'd1);
        drive(1'b1, C_ADD, 16'h3820, 5'd5, 5'd6, 5'd7);
        #1;
        chk("lu_stall", {31'd0, stall}, 32'd1);
        tick();
        chk_bubble("lu_bub");
        chk("lu_cnt", {28'd0, bubble_cnt}, 32'd1);
        chk("lu_stall_clear", {31'd0, stall}, 32'd0);
        tick();
        chk("lu_add_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_add_ctrl", {20'd0, ex_ctrl}, 32'h452);
        chk("lu_add_rd", {27'd0, ex_rd}, 32'd7);
        chk("lu_add_rs", {27'd0, ex_rs}, 32'd5);

        // Load into r0 never stalls
        drive(1'b1, C_LW, 16'h0010, 5'd1, 5'd0, 5'd0);
        tick();
        drive(1'b1, C_ADD, 16'h3820, 5'd0, 5'd6, 5'd7);
        #1;
        chk("r0_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("r0_add_valid", {31'd0, ex_valid}, 32'd1);
        chk("r0_cnt", {28'd0, bubble_cnt}, 32'd1);

        // Flush together with a hazard
        drive(1'b1, C_LW, 16'h0010, 5'd1, 5'd5, 5'd0);
        tick();
        drive(1'b1, C_ADD, 16'h3820, 5'd6, 5'd5, 5'd7);
        flush = 1'b1;
        #1;
        chk("fl_stall", {31'd0, stall}, 32'd0);
        tick();
        flush = 1'b0;
        chk_bubble("fl_bub");
        chk("fl_cnt", {28'd0, bubble_cnt}, 32'd2);

        // Idle with a matching load in EX: no stall, no count
        drive(1'b1, C_LW, 16'h0010, 5'd1, 5'd5, 5'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, C_ADD, 16'h0000, 5'd5, 5'd5, 5'd7);
            #1;
            chk("idle_stall", {31'd0, stall}, 32'd0);
            tick();
            chk("idle_valid", {31'd0, ex_valid}, 32'd0);
            chk("idle_cnt", {28'd0, bubble_cnt}, 32'd2);
        end

        // Reset while stalling
        drive(1'b1, C_LW, 16'h0010, 5'd1, 5'd5, 5'd0);
        tick();
        drive(1'b1, C_ADD, 16'h3820, 5'd5, 5'd6, 5'd7);
        #1;
        chk("mid_stall_pre", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_stall_rst", {31'd0, stall}, 32'd0);
        tick();
        rst = 1'b0;
        chk_bubble("mid_rst");
        chk("mid_rst_cnt", {28'd0, bubble_cnt}, 32'd0);
        #1;
        chk("mid_rst_stall_after", {31'd0, stall}, 32'd0);

        // Saturation via repeated load-use hazards
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, C_LW, 16'h0010, 5'd1, 5'd5, 5'd0);
            tick();
            drive(1'b1, C_ADD, 16'h3820, 5'd5, 5'd6, 5'd7);
            #1;
            chk("sat_stall", {31'd0, stall}, 32'd1);
            tick();
            chk("sat_cnt", {28'd0, bubble_cnt}, (i + 1 > 15) ? 32'd15 : 32'(i + 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
